// File: rtl/bht_port_scheduler_pkg.sv
// Shared encodings and the saturating 2-bit counter update for the BHT port scheduler.
package bht_port_scheduler_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_JUMP = 2'd0,
    WEAK_NOT_JUMP   = 2'd1,
    WEAK_JUMP       = 2'd2,
    STRONG_JUMP     = 2'd3
  } ctr_e;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_UPD_WR = 2'd2
  } sched_state_e;

  function automatic logic [1:0] ctr_sat_upd(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == STRONG_JUMP)     ? ctr : ctr + 2'd1;
    else       return (ctr == STRONG_NOT_JUMP) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small FIFO of pending ROB counter updates; extra pointer bit separates full from empty.
module bp_upd_fifo #(
  parameter int QDEPTH = 4,
  parameter int DW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(QDEPTH);

  logic [DW-1:0] mem [QDEPTH];
  logic [AW:0]   wp, rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until a push has landed.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign head  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/bht_port_scheduler.sv
// Owns the single BHT port: init sweep, fetch lookups and 2-cycle RMW of queued ROB updates.
module bht_port_scheduler
  import bht_port_scheduler_pkg::*;
#(
  parameter int         IDX_W      = 8,
  parameter int         QDEPTH     = 4,
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] INIT_CTR   = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fch_req,
  input  logic [IDX_W-1:0] fch_idx,
  output logic             fch_gnt,
  output logic             fch_rsp_valid,
  output logic [1:0]       fch_rsp_ctr,
  output logic             fch_rsp_taken,
  input  logic             rob_upd_valid,
  input  logic [IDX_W-1:0] rob_upd_idx,
  input  logic             rob_upd_taken,
  output logic             rob_upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic             init_done
);
  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic             taken;
    logic [IDX_W-1:0] idx;
  } upd_t;

  sched_state_e     state, state_nxt;
  logic [IDX_W-1:0] init_ptr;
  logic [SW-1:0]    starve, starve_nxt;
  logic             rsp_vld;
  logic             full, empty, push, pop;
  logic [IDX_W:0]   head_raw;
  upd_t             head;
  logic             gnt, en, we;
  logic [IDX_W-1:0] addr;
  logic [1:0]       wdata;

  assign push = rob_upd_valid && rob_upd_ready;
  assign head = upd_t'(head_raw);

  bp_upd_fifo #(
    .QDEPTH (QDEPTH),
    .DW     (IDX_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({rob_upd_taken, rob_upd_idx}),
    .pop   (pop),
    .head  (head_raw),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_ptr <= '0;
      starve   <= '0;
      rsp_vld  <= 1'b0;
    end else begin
      state   <= state_nxt;
      starve  <= starve_nxt;
      rsp_vld <= gnt;
      if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    gnt        = 1'b0;
    en         = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    pop        = 1'b0;
    unique case (state)
      S_INIT: begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = init_ptr;
        wdata = INIT_CTR;
        if (&init_ptr) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // Updates win when the queue is full, fetch is quiet, or fetch has had its quota.
        if (!empty && (full || !fch_req || starve == STARVE_LIM)) begin
          en         = 1'b1;
          addr       = head.idx;
          starve_nxt = '0;
          state_nxt  = S_UPD_WR;
        end else if (fch_req) begin
          gnt  = 1'b1;
          en   = 1'b1;
          addr = fch_idx;
          if (empty)                     starve_nxt = '0;
          else if (starve != STARVE_LIM) starve_nxt = starve + SW'(1);
        end
      end
      S_UPD_WR: begin
        en        = 1'b1;
        we        = 1'b1;
        addr      = head.idx;
        wdata     = ctr_sat_upd(tbl_rdata, head.taken);
        pop       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Gate with rst_n so an asserted reset kills an in-flight write without waiting for a clock.
  assign fch_gnt       = rst_n && gnt;
  assign tbl_en        = rst_n && en;
  assign tbl_we        = rst_n && we;
  assign tbl_addr      = rst_n ? addr  : '0;
  assign tbl_wdata     = rst_n ? wdata : '0;
  assign rob_upd_ready = rst_n && !full;
  assign init_done     = rst_n && (state != S_INIT);
  assign fch_rsp_valid = rsp_vld;
  assign fch_rsp_ctr   = rsp_vld ? tbl_rdata : 2'b00;
  assign fch_rsp_taken = fch_rsp_ctr[1];

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Random + directed bench for bht_port_scheduler against a queue-based reference model.
module tb_bht_port_scheduler;
  localparam int IDX_W = 3;
  localparam int N     = 8;
  localparam int QD    = 4;
  localparam int SMAX  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fch_req = 1'b0;
  logic [IDX_W-1:0] fch_idx = '0;
  logic             fch_gnt, fch_rsp_valid, fch_rsp_taken;
  logic [1:0]       fch_rsp_ctr;
  logic             rob_upd_valid = 1'b0;
  logic [IDX_W-1:0] rob_upd_idx = '0;
  logic             rob_upd_taken = 1'b0;
  logic             rob_upd_ready;
  logic             tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic             init_done;

  always #5 clk = ~clk;

  bht_port_scheduler #(
    .IDX_W(IDX_W), .QDEPTH(QD), .STARVE_MAX(SMAX), .INIT_CTR(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fch_req(fch_req), .fch_idx(fch_idx), .fch_gnt(fch_gnt),
    .fch_rsp_valid(fch_rsp_valid), .fch_rsp_ctr(fch_rsp_ctr), .fch_rsp_taken(fch_rsp_taken),
    .rob_upd_valid(rob_upd_valid), .rob_upd_idx(rob_upd_idx), .rob_upd_taken(rob_upd_taken),
    .rob_upd_ready(rob_upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata), .init_done(init_done)
  );

  // Single-port synchronous-read table, with a side preset port for directed cases.
  logic [1:0]       sram [N];
  logic             pre_en = 1'b0;
  logic [IDX_W-1:0] pre_addr = '0;
  logic [1:0]       pre_val = '0;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) sram[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= sram[tbl_addr];
    end
    if (pre_en) sram[pre_addr] <= pre_val;
  end

  int n_cmp = 0, n_bad = 0;
  int m_init, m_starve, m_rsp_ctr;
  bit m_wr, m_rsp_v;
  int m_tbl [N];
  int m_q_idx [$];
  bit m_q_tk [$];
  bit obs_gnt, obs_en, obs_we, obs_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 0; m_starve = 0; m_wr = 0; m_rsp_v = 0; m_rsp_ctr = 0;
    m_q_idx.delete(); m_q_tk.delete();
  endtask

  // One cycle: called at a negedge, drives inputs, checks, advances the model, returns at next negedge.
  task automatic step(input bit req, input int idx, input bit uv, input int uidx, input bit ut);
    int  e_en, e_we, e_addr, e_wd, e_gnt, sz, cur;
    bit  issue, rdy;
    e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_gnt = 0; issue = 0;
    sz  = m_q_idx.size();
    rdy = (sz < QD);
    fch_req = req; fch_idx = idx[IDX_W-1:0];
    rob_upd_valid = uv; rob_upd_idx = uidx[IDX_W-1:0]; rob_upd_taken = ut;
    #1;
    obs_gnt = fch_gnt; obs_en = tbl_en; obs_we = tbl_we; obs_rdy = rob_upd_ready;
    chk("rsp_valid", fch_rsp_valid, int'(m_rsp_v));
    chk("rsp_ctr", fch_rsp_ctr, m_rsp_v ? m_rsp_ctr : 0);
    chk("rsp_taken", fch_rsp_taken, m_rsp_v ? m_rsp_ctr / 2 : 0);
    chk("init_done", init_done, int'(m_init == N));
    chk("upd_ready", rob_upd_ready, int'(rdy));
    if (m_init < N) begin
      e_en = 1; e_we = 1; e_addr = m_init; e_wd = 1;
    end else if (m_wr) begin
      cur = m_tbl[m_q_idx[0]];
      e_en = 1; e_we = 1; e_addr = m_q_idx[0];
      e_wd = m_q_tk[0] ? (cur == 3 ? 3 : cur + 1) : (cur == 0 ? 0 : cur - 1);
    end else if (sz > 0 && (sz == QD || !req || m_starve == SMAX)) begin
      issue = 1; e_en = 1; e_addr = m_q_idx[0];
    end else if (req) begin
      e_gnt = 1; e_en = 1; e_addr = idx;
    end
    chk("gnt", fch_gnt, e_gnt);
    chk("tbl_en", tbl_en, e_en);
    chk("tbl_we", tbl_we, e_we);
    if (e_en != 0) chk("tbl_addr", tbl_addr, e_addr);
    if (e_we != 0) chk("tbl_wdata", tbl_wdata, e_wd);
    m_rsp_v = (e_gnt != 0);
    if (e_gnt != 0) m_rsp_ctr = m_tbl[idx];
    if (m_init < N) begin
      m_tbl[m_init] = 1; m_init++;
    end else if (m_wr) begin
      m_tbl[m_q_idx[0]] = e_wd;
      void'(m_q_idx.pop_front()); void'(m_q_tk.pop_front());
      m_wr = 0;
    end else if (issue) begin
      m_wr = 1; m_starve = 0;
    end else if (e_gnt != 0) begin
      m_starve = (sz > 0) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    end
    if (uv && rdy) begin
      m_q_idx.push_back(uidx); m_q_tk.push_back(ut);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_q_idx.size() > 0 || m_wr) && k < 40) begin idle(); k++; end
    chk("drain_timeout", int'(m_q_idx.size() == 0 && !m_wr), 1);
  endtask

  task automatic preset(input int a, input int v);
    pre_en = 1'b1; pre_addr = a[IDX_W-1:0]; pre_val = v[1:0];
    idle();
    pre_en = 1'b0;
    m_tbl[a] = v;
  endtask

  initial begin
    int grants, k;
    bit found;
    model_reset();
    for (int i = 0; i < N; i++) m_tbl[i] = 0;

    // Reset: every output low even with requests present.
    fch_req = 1'b1; rob_upd_valid = 1'b1;
    #12;
    chk("rst_gnt", fch_gnt, 0);
    chk("rst_en", tbl_en, 0);
    chk("rst_we", tbl_we, 0);
    chk("rst_ready", rob_upd_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", fch_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Init sweep with fetch held; two updates queued during the sweep.
    for (int i = 0; i < N; i++) begin
      step(1, i, (i < 2), i + 1, 1);
      chk("init_no_gnt", obs_gnt, 0);
    end
    chk("init_done_after", init_done, 1);
    drain();

    // Saturation at both ends and mid-range increment.
    preset(5, 3); preset(6, 0); preset(7, 1);
    step(0, 0, 1, 5, 1); step(0, 0, 1, 6, 0); step(0, 0, 1, 7, 1);
    drain();

    // Back-to-back lookups.
    step(1, 5, 0, 0, 0); chk("lk5_ctr", fch_rsp_ctr, 3); chk("lk5_v", fch_rsp_valid, 1);
    step(1, 6, 0, 0, 0); chk("lk6_ctr", fch_rsp_ctr, 0); chk("lk6_v", fch_rsp_valid, 1);
    step(1, 7, 0, 0, 0); chk("lk7_ctr", fch_rsp_ctr, 2); chk("lk7_taken", fch_rsp_taken, 1);
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 2, 0, 0, 0);
    idle(); chk("b2b_end_v", fch_rsp_valid, 0);

    // Starvation: fetch held, one update arrives.
    step(1, 3, 1, 4, 0);
    grants = 0; k = 0;
    step(1, 3, 0, 0, 0);
    while (obs_gnt && k < 20) begin grants++; k++; step(1, 3, 0, 0, 0); end
    chk("starve_grants", grants, SMAX);
    chk("starve_rd", int'(obs_en && !obs_we), 1);
    step(1, 3, 0, 0, 0); chk("starve_wr", int'(obs_we && !obs_gnt), 1);
    step(1, 3, 0, 0, 0); chk("starve_resume", obs_gnt, 1);
    step(0, 0, 0, 0, 0);

    // Full FIFO pre-empts fetch; then push+pop with one free slot.
    for (int i = 0; i < QD; i++) step(1, i, 1, i, i % 2);
    step(1, 4, 1, 7, 1);
    chk("full_ready", obs_rdy, 0);
    chk("full_preempt", int'(obs_en && !obs_we && !obs_gnt), 1);
    step(0, 0, 1, 7, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 6, 1); chk("simul_wr", obs_we, 1);
    chk("simul_count", m_q_idx.size(), 3);
    idle(); chk("simul_ready", obs_rdy, 1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, N - 1), $urandom_range(0, 9) < 4,
           $urandom_range(0, N - 1), $urandom_range(0, 1));

    // Reset asserted during the write half of an update.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_wr && m_init == N) found = 1;
      else step(0, 0, 1, $urandom_range(0, N - 1), $urandom_range(0, 1));
    end
    chk("find_upd_wr", found, 1);
    fch_req = 1'b0; rob_upd_valid = 1'b0;
    #1; chk("pre_abort_we", tbl_we, int'(found));
    #2; rst_n = 1'b0;
    #1;
    chk("abort_we", tbl_we, 0);
    chk("abort_en", tbl_en, 0);
    chk("abort_ready", rob_upd_ready, 0);
    chk("abort_init_done", init_done, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1; chk("post_rst_ready", rob_upd_ready, 1);
    chk("post_rst_addr0", tbl_addr, 0);
    for (int i = 0; i < N + 4; i++) step(1, i % N, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 1),
           $urandom_range(0, N - 1), $urandom_range(0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
